// File: rtl/fsm_bit_serializer.sv
// fsm_bit_serializer
//   Takes parallel words over a valid/ready handshake and shifts them out one bit per clock on x_o.
//   x_o feeds the serial input of the FSM2 sequence detector. Back-to-back words stream with no
//   idle cycle between them. x_valid_o and last_o frame the bit stream.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: din_i[WIDTH-1] leaves first; 0: din_i[0] leaves first
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   din_i        parallel word to serialize
//   din_valid_i  din_i holds a word to send
//   din_ready_o  word can be accepted this cycle (combinational)
//   x_o          serial bit, forced to 0 when x_valid_o is low
//   x_valid_o    x_o carries a live data bit
//   last_o       x_o is the final bit of the current word
//   busy_o       a word is in flight
module fsm_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              x_q, x_d;
    logic              x_valid_q, x_valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              accept;

    // State register; the outputs are registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        accept  = din_valid_i & din_ready_o;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = din_i;
                    cnt_d   = CntW'(WIDTH - 1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    // Move the next bit into the output position.
                    shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q - CntW'(1);
                end else if (accept) begin
                    // Reload on the final bit so the next word follows without a gap.
                    shreg_d = din_i;
                    cnt_d   = CntW'(WIDTH - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: din_ready_o is combinational; the registered outputs are derived from the
    // next state so they line up with the bit sitting in the output position of shreg.
    always_comb begin
        din_ready_o = (state_q == StIdle) | ((state_q == StShift) & (cnt_q == '0));
        busy_d      = (state_d == StShift);
        x_valid_d   = busy_d;
        last_d      = busy_d & (cnt_d == '0);
        x_d         = busy_d & (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
    end

    assign x_o       = x_q;
    assign x_valid_o = x_valid_q;
    assign last_o    = last_q;
    assign busy_o    = busy_q;

endmodule
